// File: rtl/pipe_pkg.sv
// Shared constants for the generic pipeline stage register: control bit
// positions, reset control value and the default payload composition.
package pipe_pkg;

  // Control vector bit positions
  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALU_PC8  = 3;
  localparam int CTRL_DT_LH    = 4;
  localparam int CTRL_DT_SH    = 5;

  localparam int CTRL_W_DEF = 6;

  // MemtoReg comes out of reset/flush set; everything else cleared.
  localparam logic [CTRL_W_DEF-1:0] CTRL_RST_DEF = 6'b000001;

  // Data payload: ALU result, Rt data, PC+8, write register index
  localparam int ALU_W      = 32;
  localparam int RT_W       = 32;
  localparam int PC8_W      = 32;
  localparam int WREG_W     = 5;
  localparam int DATA_W_DEF = ALU_W + RT_W + PC8_W + WREG_W;

  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// master = the driving environment, slave = the stage itself.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, bubble_cnt
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, bubble_cnt
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One valid/ctrl/data holding register. Priority: reset, flush, load, clear.
// Flush turns the slot into a bubble but leaves the data field untouched.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_RST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              flush,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(negedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= CTRL_RST;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= CTRL_RST;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register with valid/ready, flush-to-bubble and a
// saturating bubble counter. Define PIPE_SKID_EN for a second (skid) slot
// and a registered in_ready. State updates on the falling clock edge.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_RST_DEF,
  parameter int                CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus
);

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              m_load, m_clr;
  logic [CTRL_W-1:0] m_d_ctrl;
  logic [DATA_W-1:0] m_d_data;
  logic              accept, pop;
  logic [CNT_W-1:0]  bcnt;

  assign pop    = m_valid && bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef PIPE_SKID_EN
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              s_load, s_clr;

  // Ready only depends on the skid flop, so no out_ready -> in_ready path.
  assign bus.in_ready = !s_valid;

  always_comb begin
    m_load   = 1'b0;
    m_clr    = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    m_d_ctrl = bus.in_ctrl;
    m_d_data = bus.in_data;
    if (pop && s_valid) begin
      // S drains into M; in_ready is low so no accept can collide
      m_load   = 1'b1;
      m_d_ctrl = s_ctrl;
      m_d_data = s_data;
      s_clr    = 1'b1;
    end else if (accept && (!m_valid || pop)) begin
      m_load = 1'b1;
    end else if (accept) begin
      s_load = 1'b1;
    end else if (pop) begin
      m_clr = 1'b1;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) u_s (
    .clk    (clk),
    .rst    (rst),
    .load   (s_load),
    .clr    (s_clr),
    .flush  (bus.flush),
    .d_ctrl (bus.in_ctrl),
    .d_data (bus.in_data),
    .valid  (s_valid),
    .ctrl   (s_ctrl),
    .data   (s_data)
  );
`else
  assign bus.in_ready = !m_valid || bus.out_ready;

  always_comb begin
    m_load   = accept;
    m_clr    = pop && !accept;
    m_d_ctrl = bus.in_ctrl;
    m_d_data = bus.in_data;
  end
`endif

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) u_m (
    .clk    (clk),
    .rst    (rst),
    .load   (m_load),
    .clr    (m_clr),
    .flush  (bus.flush),
    .d_ctrl (m_d_ctrl),
    .d_data (m_d_data),
    .valid  (m_valid),
    .ctrl   (m_ctrl),
    .data   (m_data)
  );

  // Stall-rate profiling: count cycles where downstream wanted data but got none
  always_ff @(negedge clk) begin
    if (rst)
      bcnt <= '0;
    else if (bus.out_ready && !m_valid && (bcnt != {CNT_W{1'b1}}))
      bcnt <= bcnt + 1'b1;
  end

  assign bus.out_valid  = m_valid;
  assign bus.out_ctrl   = m_ctrl;
  assign bus.out_data   = m_data;
  assign bus.bubble_cnt = bcnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, checked
// against a FIFO-of-entries model with capacity 1 (or 2 with PIPE_SKID_EN).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int CW = CTRL_W_DEF;
  localparam int NW = CNT_W_DEF;
  localparam logic [CW-1:0] CR = CTRL_RST_DEF;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int BMAX = (1 << NW) - 1;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CR), .CNT_W(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t q[$];
  ent_t shadow;
  int   bcnt;
  int   tests = 0;
  int   fails = 0;
  logic exp_ready;
  logic last_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [127:0] d);
    ent_t e;
    e.c = CW'($urandom);
    e.d = d[DW-1:0];
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return mk(r);
  endfunction

  // One clock: drive at the rising edge, check ready, advance the model,
  // then check registered outputs just after the falling (active) edge.
  task automatic step(input logic r, input logic fl, input logic iv,
                      input logic ordy, input ent_t e);
    logic pop;
    @(posedge clk);
    rst = r; bus.flush = fl; bus.in_valid = iv; bus.out_ready = ordy;
    bus.in_ctrl = e.c; bus.in_data = e.d;
    #1;
    exp_ready = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
    chk("in_ready", bus.in_ready, exp_ready);
    last_acc = 1'b0;
    if (r) begin
      q.delete();
      shadow = '{c: CR, d: '0};
      bcnt = 0;
    end else begin
      pop = (q.size() > 0) && ordy;
      last_acc = iv && exp_ready && !fl;
      if (ordy && q.size() == 0 && bcnt < BMAX) bcnt++;
      if (fl) begin
        q.delete();
        shadow.c = CR;
        last_acc = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (last_acc) q.push_back(e);
        if (q.size() > 0) shadow = q[0];
      end
    end
    @(negedge clk);
    #1;
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("out_ctrl", bus.out_ctrl, shadow.c);
    chk("out_data", bus.out_data, shadow.d);
    chk("bubble_cnt", bus.bubble_cnt, bcnt);
  endtask

  ent_t idle;
  int   idx;
  ent_t vals[3];

  initial begin
    idle = '0;
    rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_ctrl = '0; bus.in_data = '0;

    // reset while an entry is offered
    step(1, 0, 1, 0, mk(5));
    step(1, 0, 1, 0, mk(5));
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_ctrl", bus.out_ctrl, CR);
    chk("rst_data", bus.out_data, '0);
    chk("rst_bcnt", bus.bubble_cnt, '0);
    step(0, 0, 0, 0, idle);
    chk("rst_ready", bus.in_ready, 1'b1);

    // stream 1..8 at full rate
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1, 1, mk(k));
      chk("stream_data", bus.out_data, k);
    end
    step(0, 0, 0, 1, idle);

    // back-pressure for 3 cycles while offering 10, 11, 12
    vals[0] = mk(10); vals[1] = mk(11); vals[2] = mk(12);
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      step(0, 0, idx < 3, c >= 3, (idx < 3) ? vals[idx] : idle);
      if (last_acc) idx++;
      if (c == 2) chk("hold_count", q.size(), CAP);
    end

    // flush with stage full while offering 22, then accept 23
    step(0, 0, 1, 0, mk(20));
    step(0, 0, 1, 0, mk(21));
    step(0, 1, 1, 0, mk(22));
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_ctrl", bus.out_ctrl, CR);
    step(0, 0, 1, 0, mk(23));
    chk("post_flush", bus.out_data, 23);
    step(0, 0, 0, 1, idle);
    step(0, 0, 0, 1, idle);

    // bubble counter saturation; model tracks free-running idle edges
    repeat (70000) @(negedge clk);
    bcnt = (bcnt + 70000 > BMAX) ? BMAX : bcnt + 70000;
    #1;
    chk("bcnt_sat", bus.bubble_cnt, BMAX);
    step(0, 1, 0, 1, idle);
    chk("bcnt_flush", bus.bubble_cnt, BMAX);

    // reset while pop and accept coincide
    step(0, 0, 1, 0, mk(30));
    step(0, 0, 1, 0, mk(31));
    step(1, 0, 1, 1, mk(32));
    step(0, 0, 0, 1, idle);
    chk("rst_mid_valid", bus.out_valid, 1'b0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 97) == 0, ($urandom % 19) == 0, $urandom % 4 != 0,
           $urandom % 3 != 0, rnd_ent());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
